// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between memory requesters and the IorD memory access controller.
// master drives the four requests; slave (the controller) drives the mux select, write strobe and status.
interface mem_access_ctrl_if;
   logic       fetch_req;
   logic       load_req;
   logic       store_req;
   logic       exc_req;
   logic [1:0] iord_sel;
   logic       mem_wr;
   logic       busy;
   logic       done;
   logic [1:0] done_src;

   modport master (
      output fetch_req, load_req, store_req, exc_req,
      input  iord_sel, mem_wr, busy, done, done_src
   );

   modport slave (
      input  fetch_req, load_req, store_req, exc_req,
      output iord_sel, mem_wr, busy, done, done_src
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch/load/store/exception accesses onto one memory port through the IorD mux.
// Optional macro IORD_FAIRNESS_EN adds a fetch-starvation guard against back-to-back load/store grants.
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

   localparam logic [1:0] SRC_FETCH = 2'd0;
   localparam logic [1:0] SRC_LOAD  = 2'd1;
   localparam logic [1:0] SRC_STORE = 2'd2;
   localparam logic [1:0] SRC_EXC   = 2'd3;
   localparam logic [1:0] SEL_PC    = 2'd0;
   localparam logic [1:0] SEL_ALU   = 2'd1;
   localparam logic [1:0] SEL_VEC   = 2'd2;
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);

   state_t     state_q;
   logic [1:0] src_q;
   logic [3:0] wait_cnt_q;
   logic [1:0] iord_sel_q;
   logic       mem_wr_q;
   logic       busy_q;
   logic       done_q;
   logic [1:0] done_src_q;

   logic       any_req;
   logic       fetch_force;
   logic [1:0] win_src_d;
   logic [1:0] win_sel_d;

   assign any_req = bus.exc_req | bus.store_req | bus.load_req | bus.fetch_req;

`ifdef IORD_FAIRNESS_EN
   logic [1:0] fair_cnt_q;

   assign fetch_force = (fair_cnt_q == 2'd3) && bus.fetch_req;

   // Counts load/store grants that left a pending fetch waiting; saturation is impossible
   // because fetch is forced through once the count reaches 3.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fair_cnt_q <= 2'd0;
      end else if (state_q == IDLE && any_req) begin
         if (win_src_d == SRC_FETCH || win_src_d == SRC_EXC) begin
            fair_cnt_q <= 2'd0;
         end else if (bus.fetch_req) begin
            fair_cnt_q <= fair_cnt_q + 2'd1;
         end
      end
   end
`else
   assign fetch_force = 1'b0;
`endif

   always_comb begin
      win_src_d = SRC_FETCH;
      if (bus.exc_req) begin
         win_src_d = SRC_EXC;
      end else if (fetch_force) begin
         win_src_d = SRC_FETCH;
      end else if (bus.store_req) begin
         win_src_d = SRC_STORE;
      end else if (bus.load_req) begin
         win_src_d = SRC_LOAD;
      end
   end

   always_comb begin
      win_sel_d = SEL_ALU;
      if (win_src_d == SRC_EXC) begin
         win_sel_d = SEL_VEC;
      end else if (win_src_d == SRC_FETCH) begin
         win_sel_d = SEL_PC;
      end
   end

   // All outputs are registered alongside the state so the mux select never glitches.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         src_q      <= SRC_FETCH;
         wait_cnt_q <= 4'd0;
         iord_sel_q <= SEL_PC;
         mem_wr_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         done_src_q <= SRC_FETCH;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q    <= ADDR;
                  src_q      <= win_src_d;
                  iord_sel_q <= win_sel_d;
                  mem_wr_q   <= (win_src_d == SRC_STORE);
                  busy_q     <= 1'b1;
               end
            end
            ADDR: begin
               mem_wr_q   <= 1'b0;
               wait_cnt_q <= WAIT_LD;
               if (src_q == SRC_STORE || WAIT_CYCLES == 0) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  done_src_q <= src_q;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt_q <= wait_cnt_q - 4'd1;
               if (wait_cnt_q == 4'd1) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  done_src_q <= src_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.iord_sel = iord_sel_q;
   assign bus.mem_wr   = mem_wr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.done_src = done_src_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected completions are queued at stimulus time and
// popped by a monitor on each done pulse; a second instance covers the zero-latency build.
module tb_mem_access_ctrl;

   localparam int W = 2;

   typedef struct {
      logic [1:0] src;
      int         cyc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb_q[$];

   mem_access_ctrl_if bus ();
   mem_access_ctrl_if bus0 ();

   mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic push_exp(input logic [1:0] src, input int at_cyc);
      exp_t e;
      e.src = src;
      e.cyc = at_cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input int n, input int bound);
      int seen;
      seen = 0;
      for (int i = 0; i < bound && seen < n; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      if (seen < n) check_val("done_timeout", seen, n);
   endtask

   // Completion monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("done_src", bus.done_src, e.src);
            check_val("done_cycle", cyc, e.cyc);
            $display("[TB] done src=%0d at cycle %0d (expected src=%0d cycle %0d)",
                     bus.done_src, cyc, e.src, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int fc;
      logic [1:0] s;

      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      bus.fetch_req = 1'b0;  bus.load_req = 1'b0;  bus.store_req = 1'b0;  bus.exc_req = 1'b0;
      bus0.fetch_req = 1'b0; bus0.load_req = 1'b0; bus0.store_req = 1'b0; bus0.exc_req = 1'b0;

      repeat (3) @(negedge clk);
      check_val("rst_iord_sel", bus.iord_sel, 0);
      check_val("rst_mem_wr", bus.mem_wr, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_done_src", bus.done_src, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single fetch pulse; a load pulsed while busy must be ignored.
      k = cyc;
      bus.fetch_req = 1'b1;
      push_exp(2'd0, k + 2 + W);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      check_val("fetch_iord_sel", bus.iord_sel, 0);
      check_val("fetch_busy_c1", bus.busy, 1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         check_val("fetch_busy", bus.busy, 1);
         bus.load_req = (i == 2);
      end
      @(negedge clk);
      check_val("fetch_busy_after", bus.busy, 0);
      @(negedge clk);

      // Store and load together: store first, then load after one IDLE cycle.
      k = cyc;
      bus.store_req = 1'b1;
      bus.load_req  = 1'b1;
      push_exp(2'd2, k + 2);
      push_exp(2'd1, k + 7);
      @(negedge clk);
      check_val("st_mem_wr_c1", bus.mem_wr, 1);
      check_val("st_iord_sel", bus.iord_sel, 1);
      @(negedge clk);
      check_val("st_mem_wr_c2", bus.mem_wr, 0);
      check_val("st_done_c2", bus.done, 1);
      bus.store_req = 1'b0;
      wait_done(1, 20);
      bus.load_req = 1'b0;
      @(negedge clk);
      check_val("ld_iord_hold", bus.iord_sel, 1);
      check_val("ld_mem_wr_low", bus.mem_wr, 0);
      @(negedge clk);

      // Fetch and load held continuously: fairness decides whether fetch gets a turn.
      k = cyc;
      bus.fetch_req = 1'b1;
      bus.load_req  = 1'b1;
      fc = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef IORD_FAIRNESS_EN
         if (fc == 3) begin
            s  = 2'd0;
            fc = 0;
         end else begin
            s  = 2'd1;
            fc = fc + 1;
         end
`else
         s = 2'd1;
`endif
         push_exp(s, k + 2 + W + i * (3 + W));
      end
      wait_done(4, 60);
      bus.fetch_req = 1'b0;
      bus.load_req  = 1'b0;
      @(negedge clk);
      check_val("fair_idle_busy", bus.busy, 0);
      @(negedge clk);

      // All four requests pulsed together: exception wins.
      k = cyc;
      bus.fetch_req = 1'b1; bus.load_req = 1'b1; bus.store_req = 1'b1; bus.exc_req = 1'b1;
      push_exp(2'd3, k + 2 + W);
      @(negedge clk);
      bus.fetch_req = 1'b0; bus.load_req = 1'b0; bus.store_req = 1'b0; bus.exc_req = 1'b0;
      check_val("exc_iord_sel", bus.iord_sel, 2);
      check_val("exc_mem_wr", bus.mem_wr, 0);
      wait_done(1, 20);
      @(negedge clk);

      // Zero-latency instance: load completes two cycles after sampling.
      bus0.load_req = 1'b1;
      @(negedge clk);
      bus0.load_req = 1'b0;
      check_val("w0_iord_sel", bus0.iord_sel, 1);
      check_val("w0_busy", bus0.busy, 1);
      check_val("w0_done_c1", bus0.done, 0);
      @(negedge clk);
      check_val("w0_done_c2", bus0.done, 1);
      check_val("w0_done_src", bus0.done_src, 1);
      @(negedge clk);
      check_val("w0_done_c3", bus0.done, 0);
      check_val("w0_busy_c3", bus0.busy, 0);
      $display("[TB] zero-latency load checked at cycle %0d", cyc);

      // Reset during a fetch: no done, outputs cleared, request ignored until release.
      k = cyc;
      bus.fetch_req = 1'b1;
      @(negedge clk);
      check_val("abort_busy", bus.busy, 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_val("abort_iord_sel", bus.iord_sel, 0);
      check_val("abort_mem_wr", bus.mem_wr, 0);
      check_val("abort_busy_rst", bus.busy, 0);
      check_val("abort_done", bus.done, 0);
      check_val("abort_done_src", bus.done_src, 0);
      @(negedge clk);
      check_val("rst_ignore_req", bus.busy, 0);
      reset_n = 1'b1;
      push_exp(2'd0, cyc + 2 + W);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      check_val("resume_busy", bus.busy, 1);
      wait_done(1, 20);

      repeat (4) @(negedge clk);
      check_val("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
